// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: register index type and the
// bundle of pipeline control outputs produced each cycle.
package hazard_pkg;

  localparam int RW = 5;

  typedef logic [RW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic control_stall;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, control_stall: 1'b0};
  localparam hz_ctrl_t HZ_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, control_stall: 1'b1};
  localparam hz_ctrl_t HZ_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, control_stall: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load scoreboard and IF/ID stall/flush control for the 5-stage core.
// Decisions are combinational from the current inputs and registered state.
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int RW        = 5,
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_branch_tkn,
  input  logic             rsp_valid,
  input  logic [RW-1:0]    rsp_rd,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             control_stall,
  output logic             outst_full,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import hazard_pkg::*;

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [OW-1:0]    outst_q, outst_d;

  logic             ex_load;
  logic             full;
  logic             struct_haz;
  logic             stall;
  logic             issue;
  logic             rsp_dec;
  logic [1:0]       raw;
  logic [1:0][RW-1:0] src;
  logic [1:0]       use_src;
  hz_ctrl_t         ctrl;

  assign ex_load    = ex_valid && ex_mem_read;
  assign full       = (outst_q == OUTST_MAX);
  // A response this cycle frees a slot, so a load at the limit may still go.
  assign struct_haz = ex_load && full && !rsp_valid;

  assign src     = {id_rs2, id_rs1};
  assign use_src = {id_use_rs2, id_use_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_raw
      assign raw[gi] = use_src[gi] && (src[gi] != '0) &&
                       (pend_q[src[gi]] || (ex_load && (ex_rd == src[gi])));
    end
  endgenerate

  assign stall   = id_valid && ((|raw) || struct_haz);
  assign issue   = ex_load && !ex_branch_tkn && !struct_haz;
  assign rsp_dec = rsp_valid && (outst_q != '0);

  always_comb begin
    ctrl = HZ_RUN;
    if (!rst_n) begin
      ctrl = HZ_RUN;
    end else if (ex_branch_tkn) begin
      ctrl = HZ_FLUSH;
    end else if (stall) begin
      ctrl = HZ_STALL;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (rsp_valid) begin
      pend_d[rsp_rd] = 1'b0;
    end
    // Set after clear: a newer load to the same register keeps it pending.
    if (issue && (ex_rd != '0)) begin
      pend_d[ex_rd] = 1'b1;
    end
  end

  always_comb begin
    outst_d = outst_q;
    case ({issue, rsp_dec})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      outst_q <= '0;
    end else begin
      pend_q  <= pend_d;
      outst_q <= outst_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall && !ex_branch_tkn),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ex_branch_tkn),
    .count (flush_cnt)
  );

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign control_stall = ctrl.control_stall;
  assign outst_full    = full;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic, each cycle
// compared against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  localparam int RW   = 5;
  localparam int MAXO = 2;
  localparam int CW   = 6;
  localparam int SAT  = (1 << CW) - 1;
  localparam int OUTW = 5 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_rs1, id_use_rs2;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd, rsp_rd;
  logic          ex_valid, ex_mem_read, ex_branch_tkn, rsp_valid;
  logic          pc_write, if_id_write, if_id_flush, control_stall, outst_full;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_scoreboard #(.NREGS(32), .RW(RW), .MAX_OUTST(MAXO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_branch_tkn (ex_branch_tkn),
    .rsp_valid     (rsp_valid),
    .rsp_rd        (rsp_rd),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .control_stall (control_stall),
    .outst_full    (outst_full),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: set of registers with a load in flight, a count of
  // loads awaiting data, and the two event tallies.
  bit m_pend [32];
  int m_outst;
  int m_scnt;
  int m_fcnt;

  wire [OUTW-1:0] obs = {pc_write, if_id_write, if_id_flush, control_stall,
                         outst_full, stall_cnt, flush_cnt};

  typedef struct packed {
    logic          rst;
    logic          idv;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic          exv;
    logic          exmr;
    logic [RW-1:0] exrd;
    logic          br;
    logic          rspv;
    logic [RW-1:0] rsprd;
    logic [1:0]    cs;  // expected control_stall, 2 = not hand-checked
    logic [1:0]    fl;  // expected outst_full, 2 = not hand-checked
  } stim_t;

  function automatic stim_t st(input logic rst, input logic idv, input int rs1, input int rs2,
                               input logic u1, input logic u2, input logic exv, input logic exmr,
                               input int exrd, input logic br, input logic rspv, input int rsprd,
                               input int cs, input int fl);
    stim_t s;
    s.rst = rst;  s.idv = idv;  s.rs1 = RW'(rs1);  s.rs2 = RW'(rs2);
    s.u1 = u1;    s.u2 = u2;    s.exv = exv;       s.exmr = exmr;
    s.exrd = RW'(exrd);  s.br = br;  s.rspv = rspv;  s.rsprd = RW'(rsprd);
    s.cs = 2'(cs);  s.fl = 2'(fl);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst_n = s.rst;  id_valid = s.idv;  id_rs1 = s.rs1;  id_rs2 = s.rs2;
    id_use_rs1 = s.u1;  id_use_rs2 = s.u2;  ex_valid = s.exv;  ex_mem_read = s.exmr;
    ex_rd = s.exrd;  ex_branch_tkn = s.br;  rsp_valid = s.rspv;  rsp_rd = s.rsprd;
  endtask

  function automatic bit src_hit(input logic use_s, input int s);
    if (!use_s || s == 0) return 1'b0;
    return m_pend[s] || (ex_valid && ex_mem_read && int'(ex_rd) == s);
  endfunction

  function automatic bit no_slot();
    return ex_valid && ex_mem_read && m_outst == MAXO && !rsp_valid;
  endfunction

  function automatic bit want_stall();
    return id_valid && (src_hit(id_use_rs1, int'(id_rs1)) ||
                        src_hit(id_use_rs2, int'(id_rs2)) || no_slot());
  endfunction

  function automatic logic [OUTW-1:0] model_out();
    logic [3:0] c;
    if (!rst_n)             c = 4'b1100;
    else if (ex_branch_tkn) c = 4'b1111;
    else if (want_stall())  c = 4'b0001;
    else                    c = 4'b1100;
    return {c, (m_outst == MAXO), CW'(m_scnt), CW'(m_fcnt)};
  endfunction

  function automatic void model_step();
    bit iss, dec, stl;
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_outst = 0;  m_scnt = 0;  m_fcnt = 0;
      return;
    end
    stl = want_stall();
    iss = ex_valid && ex_mem_read && !ex_branch_tkn && !no_slot();
    dec = rsp_valid && m_outst > 0;
    if (rsp_valid) m_pend[rsp_rd] = 1'b0;
    if (iss && ex_rd != 0) m_pend[ex_rd] = 1'b1;
    m_outst = m_outst + int'(iss) - int'(dec);
    if (stl && !ex_branch_tkn) m_scnt = (m_scnt < SAT) ? m_scnt + 1 : SAT;
    if (ex_branch_tkn) m_fcnt = (m_fcnt < SAT) ? m_fcnt + 1 : SAT;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [OUTW-1:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      apply(st(1'b0, 1'b1, 5, 6, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 0, 2, 2));
      @(negedge clk);
      exp_v = model_out();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL reset[%0d] outputs: got %h want %h", i, obs, exp_v);
      end
      n_cmp++;
      if ({pc_write, if_id_write, if_id_flush, control_stall, stall_cnt, flush_cnt} !==
          {4'b1100, CW'(0), CW'(0)}) begin
        n_bad++;
        $display("FAIL reset_const[%0d]: got ctrl=%b%b%b%b sc=%0d fc=%0d want ctrl=1100 sc=0 fc=0",
                 i, pc_write, if_id_write, if_id_flush, control_stall, stall_cnt, flush_cnt);
      end
      tick();
    end
  endtask

  task automatic run_table(input string name, input stim_t seq [$]);
    logic [OUTW-1:0] exp_v;
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      exp_v = model_out();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL %s[%0d] model: got %h want %h", name, i, obs, exp_v);
      end
      if (seq[i].cs != 2'd2) begin
        n_cmp++;
        if (control_stall !== seq[i].cs[0]) begin
          n_bad++;
          $display("FAIL %s[%0d] control_stall: got %b want %b", name, i, control_stall, seq[i].cs[0]);
        end
      end
      if (seq[i].fl != 2'd2) begin
        n_cmp++;
        if (outst_full !== seq[i].fl[0]) begin
          n_bad++;
          $display("FAIL %s[%0d] outst_full: got %b want %b", name, i, outst_full, seq[i].fl[0]);
        end
      end
      $display("txn %s[%0d] ctrl=%b%b%b%b full=%b sc=%0d fc=%0d", name, i, pc_write, if_id_write,
               if_id_flush, control_stall, outst_full, stall_cnt, flush_cnt);
      tick();
    end
  endtask

  task automatic test_load_use();
    stim_t q [$];
    q.push_back(st(1, 1, 5, 1, 1, 1, 1, 1, 5, 0, 0, 0, 1, 2));
    q.push_back(st(1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 1, 5, 2, 2));
    q.push_back(st(1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("load_use", q);
  endtask

  task automatic test_delayed_rsp();
    stim_t q [$];
    q.push_back(st(1, 1, 5, 1, 1, 1, 1, 1, 5, 0, 0, 0, 1, 2));
    for (int i = 0; i < 3; i++) q.push_back(st(1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    q.push_back(st(1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 1, 5, 2, 2));
    q.push_back(st(1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("delayed_rsp", q);
  endtask

  task automatic test_x0_load();
    stim_t q [$];
    q.push_back(st(1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(st(1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(st(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("x0_load", q);
  endtask

  task automatic test_structural();
    stim_t q [$];
    q.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
    q.push_back(st(1, 1, 10, 11, 1, 1, 1, 1, 3, 0, 0, 0, 1, 1));
    q.push_back(st(1, 1, 10, 11, 1, 1, 1, 1, 3, 0, 1, 1, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("structural", q);
  endtask

  task automatic test_branch_vs_stall();
    stim_t q [$];
    int sc0;
    int fc0;
    sc0 = int'(stall_cnt);
    fc0 = int'(flush_cnt);
    apply(st(1, 1, 5, 1, 1, 1, 1, 1, 5, 1, 0, 0, 1, 0));
    @(negedge clk);
    n_cmp++;
    if ({pc_write, if_id_write, if_id_flush, control_stall} !== 4'b1111) begin
      n_bad++;
      $display("FAIL branch_ctrl: got %b%b%b%b want 1111", pc_write, if_id_write, if_id_flush, control_stall);
    end
    $display("txn branch_vs_stall ctrl=%b%b%b%b", pc_write, if_id_write, if_id_flush, control_stall);
    tick();
    q.push_back(st(1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("after_branch", q);
    n_cmp++;
    if (int'(stall_cnt) != sc0 || int'(flush_cnt) != fc0 + 1) begin
      n_bad++;
      $display("FAIL branch_counts: got sc=%0d fc=%0d want sc=%0d fc=%0d", stall_cnt, flush_cnt, sc0, fc0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    stim_t q [$];
    q.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0));
    q.push_back(st(1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    q.push_back(st(0, 1, 7, 0, 1, 0, 1, 1, 7, 0, 0, 0, 0, 2));
    q.push_back(st(1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0));
    q.push_back(st(1, 1, 7, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    run_table("reset_mid", q);
  endtask

  task automatic test_saturation();
    stim_t q [$];
    for (int i = 0; i < SAT + 6; i++) q.push_back(st(1, 1, 3, 0, 1, 0, 1, 1, 3, 1, 0, 0, 1, 2));
    run_table("saturation", q);
    @(negedge clk);
    n_cmp++;
    if (flush_cnt !== CW'(SAT)) begin
      n_bad++;
      $display("FAIL flush_sat: got %0d want %0d", flush_cnt, SAT);
    end
  endtask

  task automatic test_random();
    stim_t q [$];
    for (int i = 0; i < 400; i++) begin
      q.push_back(st(($urandom_range(0, 63) != 0), 1'($urandom), $urandom_range(0, 7),
                     $urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), $urandom_range(0, 7), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) < 3), $urandom_range(0, 7), 2, 2));
    end
    run_table("random", q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));
    m_outst = 0;  m_scnt = 0;  m_fcnt = 0;
    test_reset();
    test_load_use();
    test_delayed_rsp();
    test_x0_load();
    test_structural();
    test_branch_vs_stall();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
